menu_key_press_detector: RTL and testbench

Conditions the raw front-panel menu key into clean, classified press events for the mode-control path. Synchronises and debounces the key, then separates short presses from long holds. A long hold produces the single-cycle `toggle_signal` consumed by the setting-mode controller, which enters setting mode while the hood is in STAND mode. A short press produces a separate `short_press` pulse for the menu/selection logic.

---
 rtl/menu_key_press_detector.sv | 112 +++++++++++
 tb/tb_menu_key_press_detector.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/menu_key_press_detector.sv
// Front-panel menu key conditioner: synchronises and debounces the raw key,
// then classifies each press as a short press or a long hold (toggle).
module menu_key_press_detector #(
  parameter int DEBOUNCE_CYCLES   = 20000,
  parameter int LONG_PRESS_CYCLES = 3000000
) (
  input  logic clk,
  input  logic rstn,
  input  logic key_raw,
  output logic key_level,
  output logic short_press,
  output logic toggle_signal
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HELD
  } state_t;

  logic              sync1;
  logic              key_sync;
  logic [DB_W-1:0]   db_cnt;
  state_t            state;
  state_t            next_state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] next_hold;
  logic              next_short;
  logic              next_toggle;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1    <= 1'b0;
      key_sync <= 1'b0;
    end else begin
      sync1    <= key_raw;
      key_sync <= sync1;
    end
  end

  // The level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples;
  // any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      db_cnt    <= '0;
      key_level <= 1'b0;
    end else if (key_sync == key_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt    <= '0;
      key_level <= key_sync;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      short_press   <= 1'b0;
      toggle_signal <= 1'b0;
    end else begin
      state         <= next_state;
      hold_cnt      <= next_hold;
      short_press   <= next_short;
      toggle_signal <= next_toggle;
    end
  end

  // Release is checked before the threshold so a coincident release gives a short press.
  always_comb begin
    next_state  = state;
    next_hold   = hold_cnt;
    next_short  = 1'b0;
    next_toggle = 1'b0;
    case (state)
      IDLE: begin
        if (key_level) begin
          next_state = PRESSED;
          next_hold  = '0;
        end
      end
      PRESSED: begin
        if (!key_level) begin
          next_short = 1'b1;
          next_state = IDLE;
        end else if (hold_cnt == HOLD_LAST) begin
          next_toggle = 1'b1;
          next_state  = HELD;
        end else begin
          next_hold = hold_cnt + HOLD_W'(1);
        end
      end
      HELD: begin
        if (!key_level) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_menu_key_press_detector.sv
// Table-driven bench for menu_key_press_detector: expected per-cycle outputs are
// queued as stimulus is driven and compared by a monitor on the falling edge.
module tb_menu_key_press_detector;

  logic clk;
  logic rstn;
  logic key_raw;
  logic key_level;
  logic short_press;
  logic toggle_signal;

  menu_key_press_detector #(
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(10)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .key_raw      (key_raw),
    .key_level    (key_level),
    .short_press  (short_press),
    .toggle_signal(toggle_signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raw windows are inclusive cycle ranges; level windows are [rise, fall).
  typedef struct {
    string name;
    int    cycles;
    int    on_a, off_a, on_b, off_b;
    int    rise_a, fall_a, rise_b, fall_b;
    int    short_a, short_b, toggle_at;
  } vec_t;

  typedef struct {
    string name;
    int    cyc;
    logic  lvl;
    logic  sp;
    logic  tg;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  vec_t vecs[8];

  function automatic vec_t make_vec(string name, int cycles,
                                    int on_a, int off_a, int on_b, int off_b,
                                    int rise_a, int fall_a, int rise_b, int fall_b,
                                    int short_a, int short_b, int toggle_at);
    vec_t v;
    v.name = name;      v.cycles = cycles;
    v.on_a = on_a;      v.off_a = off_a;    v.on_b = on_b;     v.off_b = off_b;
    v.rise_a = rise_a;  v.fall_a = fall_a;  v.rise_b = rise_b; v.fall_b = fall_b;
    v.short_a = short_a; v.short_b = short_b; v.toggle_at = toggle_at;
    return v;
  endfunction

  task automatic push_expect(string name, int cyc, logic lvl, logic sp, logic tg);
    exp_t e;
    e.name = name;
    e.cyc  = cyc;
    e.lvl  = lvl;
    e.sp   = sp;
    e.tg   = tg;
    sb_q.push_back(e);
  endtask

  // Reset is held for four cycles while key_raw toggles; outputs must stay 0.
  task automatic reset_phase(string name);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      rstn    = 1'b0;
      key_raw = i[0];
      push_expect({name, "_rst"}, -1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Cycle n's key_raw is driven before edge n; cycle n's outputs are sampled just before edge n.
  task automatic apply_stimulus(vec_t v);
    logic lvl;
    reset_phase(v.name);
    for (int n = 0; n < v.cycles; n++) begin
      @(posedge clk); #1;
      rstn    = 1'b1;
      key_raw = (n >= v.on_a && n <= v.off_a) || (n >= v.on_b && n <= v.off_b);
      lvl     = (n >= v.rise_a && n < v.fall_a) || (n >= v.rise_b && n < v.fall_b);
      push_expect(v.name, n, lvl, (n == v.short_a) || (n == v.short_b), n == v.toggle_at);
    end
  endtask

  // Key held throughout; rstn pulsed low across edge 12, so edge 13 acts as the new edge 0.
  task automatic mid_press_reset();
    logic lvl;
    reset_phase("mid_reset");
    for (int n = 0; n < 45; n++) begin
      @(posedge clk); #1;
      rstn    = (n != 12);
      key_raw = 1'b1;
      lvl     = (n >= 6 && n < 12) || (n >= 19);
      push_expect("mid_reset", n, lvl, 1'b0, n == 30);
    end
  endtask

  task automatic check_output(exp_t e);
    vectors++;
    if ({key_level, short_press, toggle_signal} !== {e.lvl, e.sp, e.tg}) begin
      miscompares++;
      $display("[TB] FAIL %s cycle %0d: got level/short/toggle=%b%b%b expected %b%b%b",
               e.name, e.cyc, key_level, short_press, toggle_signal, e.lvl, e.sp, e.tg);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      check_output(mon_e);
    end
  end

  initial begin
    rstn    = 1'b1;
    key_raw = 1'b0;
    #2 rstn = 1'b0;

    vecs[0] = make_vec("no_press",   60, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1);
    vecs[1] = make_vec("glitch3",    60, 10, 12, -1, -1, -1, -1, -1, -1, -1, -1, -1);
    vecs[2] = make_vec("min_pulse4", 60, 10, 13, -1, -1, 16, 20, -1, -1, 21, -1, -1);
    vecs[3] = make_vec("long40",     60,  0, 39, -1, -1,  6, 46, -1, -1, -1, -1, 17);
    vecs[4] = make_vec("short8",     60,  0,  7, -1, -1,  6, 14, -1, -1, 15, -1, -1);
    vecs[5] = make_vec("edge_short", 60,  0,  9, -1, -1,  6, 16, -1, -1, 17, -1, -1);
    vecs[6] = make_vec("edge_long",  60,  0, 10, -1, -1,  6, 17, -1, -1, -1, -1, 17);
    vecs[7] = make_vec("two_short",  60,  0,  7, 20, 27,  6, 14, 26, 34, 15, 35, -1);

    foreach (vecs[i]) apply_stimulus(vecs[i]);
    mid_press_reset();

    repeat (3) @(posedge clk);
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
